// File: rtl/seg7_scan_if.sv
// Bundle of digit inputs and display pins for the seg7_scan multiplexed display driver.
// The master side drives the BCD digits and watches the display pins; the slave side is the driver.
interface seg7_scan_if;
  logic [3:0] y2;
  logic [3:0] y1;
  logic [3:0] y0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  modport master (output y2, y1, y0, input an, seg, dp, frame);
  modport slave  (input y2, y1, y0, output an, seg, dp, frame);
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 3-digit active-low 7-segment driver with per-frame snapshot and slot dead time.
// Optional leading-zero blanking is enabled by defining the macro LZB_EN.
module seg7_scan #(
  parameter int SLOT_CYC  = 4,
  parameter int BLANK_CYC = 1,
  parameter int DP_POS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int                CNT_W  = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(SLOT_CYC - 1);
  localparam logic [1:0]        DP_SEL = 2'(DP_POS);

  typedef enum logic [1:0] {
    SEL_D0 = 2'd0,
    SEL_D1 = 2'd1,
    SEL_D2 = 2'd2
  } sel_e;

  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sel_e             sel_q, sel_d;
  logic [3:0]       snap2_q, snap2_d, snap1_q, snap1_d, snap0_q, snap0_d;
  logic [2:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;
  logic             take_snap;
  logic [3:0]       digit;
  logic             dig_blank;
  logic             slot_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = 7'h3F;
    endcase
  endfunction

  // Scan sequencing: the first edge after reset only snapshots, so every frame is 3*SLOT_CYC long.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    started_d = 1'b1;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    snap2_d   = snap2_q;
    snap1_d   = snap1_q;
    snap0_d   = snap0_q;
    take_snap = 1'b0;
    if (!started_q) begin
      take_snap = 1'b1;
    end else if (cnt_q == LAST_C) begin
      cnt_d = '0;
      case (sel_q)
        SEL_D0:  sel_d = SEL_D1;
        SEL_D1:  sel_d = SEL_D2;
        default: begin
          sel_d     = SEL_D0;
          take_snap = 1'b1;
        end
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (take_snap) begin
      snap2_d = bus.y2;
      snap1_d = bus.y1;
      snap0_d = bus.y0;
    end
  end

  // Outputs are registered from next-state so the pins line up with the (sel, cnt) just entered.
  always_comb begin
    case (sel_d)
      SEL_D2:  digit = snap2_d;
      SEL_D1:  digit = snap1_d;
      default: digit = snap0_d;
    endcase
`ifdef LZB_EN
    dig_blank = ((sel_d == SEL_D2) && (snap2_d == 4'd0)) ||
                ((sel_d == SEL_D1) && (snap2_d == 4'd0) && (snap1_d == 4'd0) && (DP_POS != 1));
`else
    dig_blank = 1'b0;
`endif
    slot_blank = int'(cnt_d) < BLANK_CYC;
    an_d       = 3'b111;
    seg_d      = 7'h7F;
    dp_d       = 1'b1;
    frame_d    = take_snap;
    if (!slot_blank) begin
      an_d  = ~(3'b001 << sel_d);
      seg_d = dig_blank ? 7'h7F : bcd_to_seg(digit);
      dp_d  = (2'(sel_d) == DP_SEL) ? 1'b0 : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= SEL_D0;
      snap2_q   <= 4'd0;
      snap1_q   <= 4'd0;
      snap0_q   <= 4'd0;
      an_q      <= 3'b111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      started_q <= started_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      snap2_q   <= snap2_d;
      snap1_q   <= snap1_d;
      snap0_q   <= snap0_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule
